// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types for the router output arbiters.
// Holds the AXI-Stream master/slave payloads used on every router port and
// the arbiter state encoding shared by the per-output arbiters.
package axis_packet_arbiter_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;
    localparam int unsigned AXIS_ID_WIDTH   = 3;

    // Forward channel: TVALID plus payload (data, TLAST, TID).
    typedef struct packed {
        logic                       tvalid;
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic                       tlast;
        logic [AXIS_ID_WIDTH-1:0]   tid;
    } axis_mosi_t;

    // Backward channel: TREADY only.
    typedef struct packed {
        logic tready;
    } axis_miso_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker, purely combinational.
// Scans requests starting one past last_i and wrapping modulo N; reports
// whether any request is set and the index of the first one found.
// Ports:
//   req_i   - request vector, one bit per requester
//   last_i  - index granted most recently (lowest priority this round)
//   found_o - at least one request is set
//   idx_o   - winning index, always < N
module rr_priority_picker #(
    parameter int unsigned N = 5,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    // Offsets 1..N visit every requester once, the previous owner last.
    always_comb begin
        int unsigned cand;
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = 32'(last_i) + off;
            // Subtract instead of modulo: cand never exceeds 2N-1.
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found_o && req_i[W'(cand)]) begin
                found_o = 1'b1;
                idx_o   = W'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one router output channel.
// A granted requester owns the output from its first beat through TLAST;
// one IDLE cycle separates consecutive packets for arbitration.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   in_mosi_i    - requester streams
//   in_miso_o    - per-requester TREADY (only the owner sees downstream ready)
//   out_mosi_o   - shared output stream (pass-through of the owner)
//   out_miso_i   - shared output TREADY
//   grant_o      - owning requester index, valid while busy_o=1
//   busy_o       - output locked to a packet
//   pkt_cnt_o    - packets completed since reset, wraps
module axis_packet_arbiter
    import axis_packet_arbiter_pkg::*;
#(
    parameter int unsigned CHANNEL_NUMBER       = 5,
    parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int unsigned PKT_CNT_WIDTH        = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  axis_mosi_t                      in_mosi_i [CHANNEL_NUMBER],
    output axis_miso_t                      in_miso_o [CHANNEL_NUMBER],
    output axis_mosi_t                      out_mosi_o,
    input  axis_miso_t                      out_miso_i,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] grant_o,
    output logic                            busy_o,
    output logic [PKT_CNT_WIDTH-1:0]        pkt_cnt_o
);

    arb_state_e                      state_q, state_d;
    logic [CHANNEL_NUMBER_WIDTH-1:0] grant_q, grant_d;
    logic [CHANNEL_NUMBER_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [PKT_CNT_WIDTH-1:0]        pkt_cnt_q, pkt_cnt_d;

    logic [CHANNEL_NUMBER-1:0]       req;
    logic                            pick_found;
    logic [CHANNEL_NUMBER_WIDTH-1:0] pick_idx;
    axis_mosi_t                      owner;

    // Request vector from the TVALID of each input.
    always_comb begin
        for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
            req[k] = in_mosi_i[k].tvalid;
        end
    end

    rr_priority_picker #(
        .N (CHANNEL_NUMBER),
        .W (CHANNEL_NUMBER_WIDTH)
    ) u_picker (
        .req_i   (req),
        .last_i  (last_grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner = in_mosi_i[grant_q];

    // Next state and steering; the picker only feeds registers, so downstream
    // TREADY never reaches the grant decision.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_cnt_d    = pkt_cnt_q;
        out_mosi_o   = '0;
        for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
            in_miso_o[k] = '0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                out_mosi_o         = owner;
                in_miso_o[grant_q] = out_miso_i;
                if (owner.tvalid && out_miso_i.tready && owner.tlast) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    pkt_cnt_d    = pkt_cnt_q + PKT_CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_grant resets to N-1 so input 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = (state_q == LOCKED);
    assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-input AXIS sources fed from
// beat queues, an output transfer log, and hand-computed expected orders.
module tb_axis_packet_arbiter;
    import axis_packet_arbiter_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 3;
    localparam int unsigned PW = 16;

    logic        clk = 1'b0;
    logic        rst;
    axis_mosi_t  in_mosi [N];
    axis_miso_t  in_miso [N];
    axis_mosi_t  out_mosi;
    axis_miso_t  out_miso;
    logic [W-1:0]  grant;
    logic          busy;
    logic [PW-1:0] pkt_cnt;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .CHANNEL_NUMBER       (N),
        .CHANNEL_NUMBER_WIDTH (W),
        .PKT_CNT_WIDTH        (PW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_mosi_i  (in_mosi),
        .in_miso_o  (in_miso),
        .out_mosi_o (out_mosi),
        .out_miso_i (out_miso),
        .grant_o    (grant),
        .busy_o     (busy),
        .pkt_cnt_o  (pkt_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int ch, input int pk, input int b);
        return {8'(ch), 8'(pk), 16'(b)};
    endfunction

    function automatic axis_mosi_t beat(input int ch, input int pk, input int b, input bit last);
        axis_mosi_t m;
        m.tvalid = 1'b1;
        m.tdata  = dat(ch, pk, b);
        m.tlast  = last;
        m.tid    = 3'(ch);
        return m;
    endfunction

    // Per-input sources: front of queue is driven until accepted; a beat with
    // tvalid=0 is a one-cycle bubble.
    axis_mosi_t src_q [N][$];
    logic       drv [N];
    logic       hs  [N];

    initial begin : driver
        for (int k = 0; k < N; k++) begin
            in_mosi[k] = '0;
            drv[k]     = 1'b0;
            hs[k]      = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) hs[k] = in_mosi[k].tvalid & in_miso[k].tready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (drv[k] && src_q[k].size() > 0 && (hs[k] || !src_q[k][0].tvalid))
                    void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    in_mosi[k] = src_q[k][0];
                    drv[k]     = 1'b1;
                end else begin
                    in_mosi[k] = '0;
                    drv[k]     = 1'b0;
                end
            end
        end
    end

    task automatic push_pkt(input int ch, input int pk, input int n);
        for (int b = 0; b < n; b++) src_q[ch].push_back(beat(ch, pk, b, b == n - 1));
    endtask

    // Output transfer log and the "other requester saw ready" watch.
    int          cyc = 0;
    logic [31:0] log_data [$];
    int          log_cyc [$];
    logic        watch_on = 1'b0;
    logic        early_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (out_mosi.tvalid && out_miso.tready) begin
                log_data.push_back(out_mosi.tdata);
                log_cyc.push_back(cyc);
                if (out_mosi.tlast && out_mosi.tdata[31:24] == 8'd3) watch_on = 1'b0;
            end
            if (watch_on && in_miso[1].tready) early_ready = 1'b1;
        end
    end

    // Downstream TREADY toggler, active only while tog_en is set.
    logic tog_en = 1'b0;
    initial begin : toggler
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) out_miso.tready = ~out_miso.tready;
        end
    end

    logic [31:0] exp_q [$];
    int          exp_gap [$];

    function automatic logic tready_any();
        logic r = 1'b0;
        for (int k = 0; k < N; k++) r |= in_miso[k].tready;
        return r;
    endfunction

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic wait_idle(output int c);
        bit done = 1'b0;
        bit empty;
        c = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int k = 0; k < N; k++) if (src_q[k].size() != 0) empty = 1'b0;
            if (empty && !busy) begin
                done = 1'b1;
                c    = cyc;
            end
        end
        if (!done) check("timeout_idle", 64'd0, 64'd1);
    endtask

    task automatic wait_lock(input int ch);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (busy && grant == W'(ch)) done = 1'b1;
        end
        if (!done) check("timeout_lock", 64'd0, 64'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 64'(log_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_data.size())
                check($sformatf("%s_dat%0d", tag, i), 64'(log_data[i]), 64'(exp_q[i]));
        end
        for (int i = 0; i < exp_gap.size(); i++) begin
            if (i + 1 < log_cyc.size())
                check($sformatf("%s_gap%0d", tag, i), 64'(log_cyc[i+1] - log_cyc[i]), 64'(exp_gap[i]));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        int c1;
        int c_idle;
        bit seen;

        rst = 1'b1;
        out_miso.tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state with no traffic.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_tvalid", 64'(out_mosi.tvalid), 64'd0);
            check("idle_cnt", 64'(pkt_cnt), 64'd0);
            check("idle_tready", 64'(tready_any()), 64'd0);
        end
        check("idle_grant", 64'(grant), 64'd0);

        // Input 2, 4-beat packet, downstream always ready.
        clear_log();
        push_pkt(2, 1, 4);
        @(negedge clk);
        check("t2_req_busy", 64'(busy), 64'd0);
        check("t2_req_ready", 64'(in_miso[2].tready), 64'd0);
        c1 = cyc;
        @(negedge clk);
        check("t2_lock_busy", 64'(busy), 64'd1);
        check("t2_lock_grant", 64'(grant), 64'd2);
        check("t2_lock_ready", 64'(in_miso[2].tready), 64'd1);
        check("t2_lock_tid", 64'(out_mosi.tid), 64'd2);
        wait_idle(c_idle);
        exp_q   = '{dat(2,1,0), dat(2,1,1), dat(2,1,2), dat(2,1,3)};
        exp_gap = '{1, 1, 1};
        check_log("t2");
        if (log_cyc.size() == 4) begin
            check("t2_latency", 64'(log_cyc[0] - c1), 64'd1);
            check("t2_busy_fall", 64'(c_idle - log_cyc[3]), 64'd1);
        end
        check("t2_cnt", 64'(pkt_cnt), 64'd1);

        // After reset: inputs 0, 1, 4 with 2-beat packets.
        rst = 1'b1;
        @(negedge clk);
        check("t3_rst_cnt", 64'(pkt_cnt), 64'd0);
        rst = 1'b0;
        clear_log();
        push_pkt(0, 3, 2);
        push_pkt(1, 3, 2);
        push_pkt(4, 3, 2);
        wait_idle(c_idle);
        exp_q   = '{dat(0,3,0), dat(0,3,1), dat(1,3,0), dat(1,3,1), dat(4,3,0), dat(4,3,1)};
        exp_gap = '{1, 2, 1, 2, 1};
        check_log("t3");
        check("t3_cnt", 64'(pkt_cnt), 64'd3);

        // Input 3 with bubble and toggling ready; input 1 waits throughout.
        clear_log();
        src_q[3].push_back(beat(3, 4, 0, 1'b0));
        src_q[3].push_back(beat(3, 4, 1, 1'b0));
        src_q[3].push_back('0);
        src_q[3].push_back(beat(3, 4, 2, 1'b0));
        src_q[3].push_back(beat(3, 4, 3, 1'b1));
        wait_lock(3);
        early_ready = 1'b0;
        watch_on    = 1'b1;
        push_pkt(1, 4, 2);
        tog_en = 1'b1;
        wait_idle(c_idle);
        tog_en = 1'b0;
        out_miso.tready = 1'b1;
        exp_q = '{dat(3,4,0), dat(3,4,1), dat(3,4,2), dat(3,4,3), dat(1,4,0), dat(1,4,1)};
        exp_gap.delete();
        check_log("t4");
        check("t4_early_ready", 64'(early_ready), 64'd0);
        check("t4_cnt", 64'(pkt_cnt), 64'd5);

        // Wrap/fairness: 4 served, then 4 and 0 both request -> 0 first.
        clear_log();
        push_pkt(4, 5, 1);
        push_pkt(4, 6, 1);
        wait_lock(4);
        push_pkt(0, 5, 1);
        wait_idle(c_idle);
        exp_q   = '{dat(4,5,0), dat(0,5,0), dat(4,6,0)};
        exp_gap = '{2, 2};
        check_log("t5");
        check("t5_cnt", 64'(pkt_cnt), 64'd8);

        // Counter wrap from 16'hFFFF.
        force dut.pkt_cnt_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.pkt_cnt_q;
        @(negedge clk);
        check("wrap_preload", 64'(pkt_cnt), 64'hFFFF);
        push_pkt(1, 7, 1);
        wait_idle(c_idle);
        check("wrap_cnt", 64'(pkt_cnt), 64'h0000);

        // Reset during beat 2 of a 5-beat packet.
        clear_log();
        push_pkt(2, 8, 5);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_mosi.tvalid && out_miso.tready && out_mosi.tdata == dat(2, 8, 2)) seen = 1'b1;
        end
        if (!seen) check("timeout_beat2", 64'd0, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_grant", 64'(grant), 64'd0);
        check("t6_out_zero", 64'(out_mosi != '0), 64'd0);
        check("t6_tready", 64'(tready_any()), 64'd0);
        check("t6_cnt", 64'(pkt_cnt), 64'd0);
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            drv[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        push_pkt(2, 9, 1);
        push_pkt(0, 9, 1);
        wait_idle(c_idle);
        exp_q   = '{dat(0,9,0), dat(2,9,0)};
        exp_gap = '{2};
        check_log("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
